// File: rtl/sprite_move_ctrl_pkg.sv
// Shared types and defaults for the sprite move controller.
// Optional feature macro used by the top: BORDER_CLAMP_EN.
package sprite_ctrl_pkg;

   typedef enum logic [2:0] {
      S_INIT,
      S_CLEAR,
      S_DRAW,
      S_IDLE,
      S_ERASE,
      S_STEP,
      S_WAIT
   } state_e;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   localparam int unsigned DEF_SCREEN_W  = 160;
   localparam int unsigned DEF_SCREEN_H  = 120;
   localparam logic [2:0]  DEF_BG_COLOUR = 3'b000;

endpackage

// File: rtl/sprite_move_ctrl_if.sv
// Keyboard/frame inputs and datapath/VGA control lines of the sprite move controller.
// The controller is the slave side; the keyboard decoder plus datapath form the master side.
interface sprite_move_ctrl_if;
   logic       key_valid;
   logic [1:0] key_dir;
   logic       clear_req;
   logic       frame_tick;
   logic       busy;
   logic       plot;
   logic       reset_from_controller;
   logic       ldX;
   logic       ldY;
   logic       right;
   logic       down;
   logic       ldClr;
   logic       from_control;
   logic [7:0] from_control_x;
   logic [6:0] from_control_y;
   logic       control_colour_signal;
   logic [2:0] control_colour;

   modport master (
      output key_valid, key_dir, clear_req, frame_tick,
      input  busy, plot, reset_from_controller, ldX, ldY, right, down, ldClr,
             from_control, from_control_x, from_control_y,
             control_colour_signal, control_colour
   );

   modport slave (
      input  key_valid, key_dir, clear_req, frame_tick,
      output busy, plot, reset_from_controller, ldX, ldY, right, down, ldClr,
             from_control, from_control_x, from_control_y,
             control_colour_signal, control_colour
   );
endinterface

// File: rtl/sprite_move_ctrl_sweep.sv
// Raster-order x/y counter used to sweep the whole screen during a clear.
module raster_sweep_counter #(
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       last
);

   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic       x_end, y_end;

   assign x_end = (x_q == 8'(SCREEN_W - 1));
   assign y_end = (y_q == 7'(SCREEN_H - 1));

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = '0;
         y_d = '0;
      end else if (en) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_end ? '0 : y_q + 7'd1;
         end else begin
            x_d = x_q + 8'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x    = x_q;
   assign y    = y_q;
   assign last = x_end && y_end;

endmodule

// File: rtl/sprite_move_ctrl.sv
// Moore FSM sequencing screen clear, erase/step/redraw moves and frame rate limiting.
// Define BORDER_CLAMP_EN to drop keys that would leave the visible screen.
module sprite_move_ctrl
   import sprite_ctrl_pkg::*;
#(
   parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
   parameter logic [2:0]  BG_COLOUR  = DEF_BG_COLOUR,
   parameter int unsigned FRAME_WAIT = 1
) (
   input  logic               clock,
   input  logic               reset,
   sprite_move_ctrl_if.slave  bus
);

   localparam int WAIT_W = (FRAME_WAIT > 1) ? $clog2(FRAME_WAIT) : 1;

   state_e              state_q, state_d;
   logic [1:0]          dir_q, dir_d;
   logic [7:0]          pos_x_q, pos_x_d;
   logic [6:0]          pos_y_q, pos_y_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                moved_q, moved_d;
   logic [7:0]          sweep_x;
   logic [6:0]          sweep_y;
   logic                sweep_last;
   logic                off_edge;

   raster_sweep_counter #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_sweep (
      .clock (clock),
      .reset (reset),
      .en    (state_q == S_CLEAR),
      .clr   (state_q != S_CLEAR),
      .x     (sweep_x),
      .y     (sweep_y),
      .last  (sweep_last)
   );

`ifdef BORDER_CLAMP_EN
   always_comb begin
      off_edge = 1'b0;
      case (bus.key_dir)
         DIR_UP:    off_edge = (pos_y_q == 7'd0);
         DIR_DOWN:  off_edge = (pos_y_q == 7'(SCREEN_H - 1));
         DIR_LEFT:  off_edge = (pos_x_q == 8'd0);
         DIR_RIGHT: off_edge = (pos_x_q == 8'(SCREEN_W - 1));
      endcase
   end
`else
   assign off_edge = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      wait_cnt_d = wait_cnt_q;
      moved_d    = moved_q;
      case (state_q)
         S_INIT: begin
            // The datapath registers are being reset, so the shadow follows.
            pos_x_d = '0;
            pos_y_d = '0;
            moved_d = 1'b0;
            state_d = S_CLEAR;
         end
         S_CLEAR: if (sweep_last) state_d = S_DRAW;
         S_DRAW: begin
            wait_cnt_d = '0;
            state_d    = moved_q ? S_WAIT : S_IDLE;
         end
         S_IDLE: begin
            if (bus.clear_req) begin
               moved_d = 1'b0;
               state_d = S_CLEAR;
            end else if (bus.key_valid && !off_edge) begin
               dir_d   = bus.key_dir;
               moved_d = 1'b1;
               state_d = S_ERASE;
            end
         end
         S_ERASE: state_d = S_STEP;
         S_STEP: begin
            case (dir_q)
               DIR_UP:    pos_y_d = pos_y_q - 7'd1;
               DIR_DOWN:  pos_y_d = pos_y_q + 7'd1;
               DIR_LEFT:  pos_x_d = pos_x_q - 8'd1;
               DIR_RIGHT: pos_x_d = pos_x_q + 8'd1;
            endcase
            state_d = S_DRAW;
         end
         S_WAIT: begin
            if (bus.frame_tick) begin
               if (wait_cnt_q == WAIT_W'(FRAME_WAIT - 1)) begin
                  wait_cnt_d = '0;
                  state_d    = S_IDLE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_INIT;
         dir_q      <= DIR_UP;
         pos_x_q    <= '0;
         pos_y_q    <= '0;
         wait_cnt_q <= '0;
         moved_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         wait_cnt_q <= wait_cnt_d;
         moved_q    <= moved_d;
      end
   end

   // Outputs decode from the current state; reset forces the datapath-reset pattern.
   always_comb begin
      bus.busy                  = 1'b0;
      bus.plot                  = 1'b0;
      bus.reset_from_controller = 1'b0;
      bus.ldX                   = 1'b0;
      bus.ldY                   = 1'b0;
      bus.right                 = 1'b0;
      bus.down                  = 1'b0;
      bus.ldClr                 = 1'b0;
      bus.from_control          = 1'b0;
      bus.from_control_x        = '0;
      bus.from_control_y        = '0;
      bus.control_colour_signal = 1'b0;
      bus.control_colour        = '0;
      if (reset) begin
         bus.reset_from_controller = 1'b1;
         bus.busy                  = 1'b1;
      end else begin
         bus.busy           = (state_q != S_IDLE);
         bus.from_control_x = sweep_x;
         bus.from_control_y = sweep_y;
         bus.control_colour = BG_COLOUR;
         case (state_q)
            S_INIT: begin
               bus.reset_from_controller = 1'b1;
               bus.ldClr                 = 1'b1;
            end
            S_CLEAR: begin
               bus.plot                  = 1'b1;
               bus.from_control          = 1'b1;
               bus.control_colour_signal = 1'b1;
            end
            S_DRAW: bus.plot = 1'b1;
            S_ERASE: begin
               bus.plot                  = 1'b1;
               bus.control_colour_signal = 1'b1;
            end
            S_STEP: begin
               bus.ldX   = dir_q[1];
               bus.ldY   = !dir_q[1];
               bus.right = (dir_q == DIR_RIGHT);
               bus.down  = (dir_q == DIR_DOWN);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed bench for sprite_move_ctrl: clear sweep, moves, rate limiting, drops, reset abort.
// Honours BORDER_CLAMP_EN the same way as the design.
module tb_sprite_move_ctrl;
   import sprite_ctrl_pkg::*;

   localparam int W = 160;
   localparam int H = 120;
   localparam int NPIX = W * H;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   strobe_cnt = 0;
   logic [7:0] dp_x = '0;
   logic [6:0] dp_y = '0;
   int   bad;
   int   s0;

   sprite_move_ctrl_if bus ();

   sprite_move_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference datapath driven by the controller strobes.
   always @(posedge clock) begin
      if (bus.reset_from_controller) begin
         dp_x <= '0;
         dp_y <= '0;
      end else begin
         if (bus.ldX) dp_x <= bus.right ? dp_x + 8'd1 : dp_x - 8'd1;
         if (bus.ldY) dp_y <= bus.down ? dp_y + 7'd1 : dp_y - 7'd1;
      end
      if (bus.ldX || bus.ldY) strobe_cnt <= strobe_cnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walks a clear from pixel 0 to the last pixel; pulses key_valid+clear_req at key_at.
   task automatic run_sweep(input int key_at, output int nbad);
      nbad = 0;
      for (int i = 0; i < NPIX; i++) begin
         bus.key_valid = (i == key_at);
         bus.clear_req = (i == key_at);
         if (bus.from_control_x !== 8'(i % W) || bus.from_control_y !== 7'(i / W) ||
             bus.plot !== 1'b1 || bus.from_control !== 1'b1 || bus.busy !== 1'b1)
            nbad++;
         if (i != NPIX - 1) step();
      end
      bus.key_valid = 1'b0;
      bus.clear_req = 1'b0;
   endtask

   initial begin
      bus.key_valid  = 1'b0;
      bus.key_dir    = DIR_UP;
      bus.clear_req  = 1'b0;
      bus.frame_tick = 1'b0;

      // Reset state
      step();
      step();
      check("rst_rfc",   bus.reset_from_controller, 1);
      check("rst_busy",  bus.busy, 1);
      check("rst_plot",  bus.plot, 0);
      check("rst_ldclr", bus.ldClr, 0);

      // First cycle after release is S_INIT
      reset = 1'b0;
      #1;
      check("init_rfc",   bus.reset_from_controller, 1);
      check("init_ldclr", bus.ldClr, 1);
      check("init_plot",  bus.plot, 0);

      step();
      check("clr0_rfc", bus.reset_from_controller, 0);
      run_sweep(-1, bad);
      check("clr_sweep_bad", bad, 0);
      check("clr_last_x", bus.from_control_x, 159);
      check("clr_last_y", bus.from_control_y, 119);

      step();
      check("draw_plot", bus.plot, 1);
      check("draw_fc",   bus.from_control, 0);
      check("draw_pos",  {dp_x, 1'b0, dp_y}, 0);
      step();
      check("idle_busy", bus.busy, 0);
      check("idle_plot", bus.plot, 0);

      // Move right from (0,0)
      s0 = strobe_cnt;
      bus.key_valid = 1'b1;
      bus.key_dir   = DIR_RIGHT;
      step();
      bus.key_valid = 1'b0;
      check("erase_plot", bus.plot, 1);
      check("erase_ccs",  bus.control_colour_signal, 1);
      check("erase_ldx",  bus.ldX, 0);
      step();
      check("step_ldx",   bus.ldX, 1);
      check("step_right", bus.right, 1);
      check("step_ldy",   bus.ldY, 0);
      check("step_plot",  bus.plot, 0);
      step();
      check("redraw_plot", bus.plot, 1);
      check("redraw_ccs",  bus.control_colour_signal, 0);
      check("redraw_x",    dp_x, 1);
      check("redraw_y",    dp_y, 0);
      check("shadow_x1",   dut.pos_x_q, 1);
      step();
      check("wait_busy", bus.busy, 1);

      // Key during S_WAIT is dropped
      bus.key_valid = 1'b1;
      bus.key_dir   = DIR_DOWN;
      step();
      bus.key_valid = 1'b0;
      check("waitkey_ldy",  bus.ldY, 0);
      check("waitkey_plot", bus.plot, 0);
      step();
      step();
      step();
      check("wait_hold_busy", bus.busy, 1);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      check("tick_release_busy", bus.busy, 0);
      check("move_strobes", strobe_cnt - s0, 1);

      // Simultaneous clear_req and key_valid, plus a key and clear during the clear
      s0 = strobe_cnt;
      bus.clear_req = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_dir   = DIR_LEFT;
      step();
      bus.clear_req = 1'b0;
      bus.key_valid = 1'b0;
      check("both_clear_fc", bus.from_control, 1);
      run_sweep(300, bad);
      check("clr2_sweep_bad", bad, 0);
      step();
      check("clr2_draw_plot", bus.plot, 1);
      step();
      check("clr2_idle_busy", bus.busy, 0);
      check("clr2_no_strobes", strobe_cnt - s0, 0);
      check("clr2_pos_x", dp_x, 1);
      check("clr2_shadow_x", dut.pos_x_q, 1);

      // Move left with a frame tick in the S_WAIT entry cycle
      bus.key_valid = 1'b1;
      bus.key_dir   = DIR_LEFT;
      step();
      bus.key_valid = 1'b0;
      step();
      check("left_ldx",   bus.ldX, 1);
      check("left_right", bus.right, 0);
      step();
      check("left_x", dp_x, 0);
      step();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      check("entry_tick_busy", bus.busy, 0);

      // Reset asserted at clear pixel 500
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      for (int i = 0; i < 500; i++) step();
      check("px500_x", bus.from_control_x, 20);
      check("px500_y", bus.from_control_y, 3);
      reset = 1'b1;
      step();
      check("abort_state", dut.state_q, S_INIT);
      check("abort_rfc",   bus.reset_from_controller, 1);
      check("abort_plot",  bus.plot, 0);
      reset = 1'b0;
      #1;
      check("abort_init_ldclr", bus.ldClr, 1);
      step();
      run_sweep(-1, bad);
      check("restart_sweep_bad", bad, 0);
      step();
      step();
      check("restart_idle_busy", bus.busy, 0);

      // Key left at (0,0)
      s0 = strobe_cnt;
      bus.key_valid = 1'b1;
      bus.key_dir   = DIR_LEFT;
      step();
      bus.key_valid = 1'b0;
`ifdef BORDER_CLAMP_EN
      check("clamp_busy", bus.busy, 0);
      check("clamp_plot", bus.plot, 0);
      step();
      check("clamp_busy2", bus.busy, 0);
      check("clamp_strobes", strobe_cnt - s0, 0);
      check("clamp_x", dp_x, 0);
      check("clamp_shadow_x", dut.pos_x_q, 0);
`else
      check("wrap_erase_plot", bus.plot, 1);
      step();
      check("wrap_ldx", bus.ldX, 1);
      check("wrap_right", bus.right, 0);
      step();
      check("wrap_x", dp_x, 255);
      check("wrap_shadow_x", dut.pos_x_q, 255);
      step();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      check("wrap_busy", bus.busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
